// File: rtl/exp_3x3_kerl_fetch_if.sv
// rtl/exp_3x3_kerl_fetch_if.sv - kernel RAM read port and kernel-word handoff bundle for exp_3x3_kerl_fetch
interface exp_3x3_kerl_fetch_if;
  logic         exp_3x3_kerl_ready_i;
  logic         exp_3x3_kerl_req_o;
  logic [71:0]  exp_3x3_kerl_1_data_i;
  logic [71:0]  exp_3x3_kerl_2_data_i;
  logic [71:0]  exp_3x3_kerl_3_data_i;
  logic [71:0]  exp_3x3_kerl_4_data_i;
  logic [287:0] ker_data_o;
  logic         ker_valid_o;
  logic         ker_accept_i;
  logic [6:0]   ker_group_o;
  logic         ker_last_depth_o;
  logic         ker_last_group_o;

  modport master (
    input  exp_3x3_kerl_ready_i, exp_3x3_kerl_1_data_i, exp_3x3_kerl_2_data_i,
           exp_3x3_kerl_3_data_i, exp_3x3_kerl_4_data_i, ker_accept_i,
    output exp_3x3_kerl_req_o, ker_data_o, ker_valid_o, ker_group_o,
           ker_last_depth_o, ker_last_group_o
  );

  modport slave (
    output exp_3x3_kerl_ready_i, exp_3x3_kerl_1_data_i, exp_3x3_kerl_2_data_i,
           exp_3x3_kerl_3_data_i, exp_3x3_kerl_4_data_i, ker_accept_i,
    input  exp_3x3_kerl_req_o, ker_data_o, ker_valid_o, ker_group_o,
           ker_last_depth_o, ker_last_group_o
  );
endinterface

// File: rtl/exp_3x3_kerl_fetch.sv
// rtl/exp_3x3_kerl_fetch.sv - expand 3x3 kernel fetch sequencer; EXP3_FETCH_PERF_CNT_EN adds stall_cnt_o
module exp_3x3_kerl_fetch #(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  one_exp3_ker_addr_limit_i,
  input  logic [5:0]  exp3_ker_depth_i,
  input  logic [6:0]  layer_dimension_i,
  exp_3x3_kerl_fetch_if.master kif,
  output logic        busy_o,
`ifdef EXP3_FETCH_PERF_CNT_EN
  output logic [23:0] stall_cnt_o,
`endif
  output logic        done_o
);

  localparam logic [2:0] LAT_W = 3'(RD_LATENCY);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, WAIT_DATA, HOLD, DONE} state_t;

  state_t     state, state_nxt;
  logic [6:0] limit_q, dim_q;
  logic [5:0] depth_q;
  logic [5:0] d_q;
  logic [6:0] g_q, c_q, r_q;
  logic [2:0] lat_q;
  logic       last_d, last_g, final_word, capture, accepted;

  assign last_d     = (d_q == depth_q);
  assign last_g     = (g_q == limit_q - 7'd1);
  assign final_word = last_d & last_g & (c_q == dim_q) & (r_q == dim_q);
  assign capture    = (state == WAIT_DATA) && (lat_q == LAT_W);
  assign accepted   = (state == HOLD) && kif.ker_accept_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one outstanding request, capture after the RAM latency, hold until accepted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_i) state_nxt = WAIT_RDY;
      WAIT_RDY:  if (kif.exp_3x3_kerl_ready_i) state_nxt = WAIT_DATA;
      WAIT_DATA: if (capture) state_nxt = HOLD;
      HOLD:      if (kif.ker_accept_i) state_nxt = final_word ? DONE : WAIT_RDY;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; req is a single cycle because WAIT_RDY is left on the same edge
  always_comb begin
    kif.exp_3x3_kerl_req_o = (state == WAIT_RDY) && kif.exp_3x3_kerl_ready_i;
    kif.ker_valid_o        = (state == HOLD);
    busy_o                 = (state == WAIT_RDY) || (state == WAIT_DATA) || (state == HOLD);
    done_o                 = (state == DONE);
  end

  // Config latch and loop counters: depth innermost, then group, column, row
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      limit_q <= '0;
      depth_q <= '0;
      dim_q   <= '0;
      d_q     <= '0;
      g_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
    end else if (state == IDLE && start_i) begin
      limit_q <= one_exp3_ker_addr_limit_i;
      depth_q <= exp3_ker_depth_i;
      dim_q   <= layer_dimension_i;
      d_q     <= '0;
      g_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
    end else if (accepted) begin
      if (!last_d) begin
        d_q <= d_q + 6'd1;
      end else begin
        d_q <= '0;
        if (!last_g) begin
          g_q <= g_q + 7'd1;
        end else begin
          g_q <= '0;
          if (c_q != dim_q) begin
            c_q <= c_q + 7'd1;
          end else begin
            c_q <= '0;
            r_q <= r_q + 7'd1;
          end
        end
      end
    end
  end

  // Latency counter: counts cycles since the req pulse while waiting for RAM q
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                                    lat_q <= '0;
    else if (state == WAIT_RDY && kif.exp_3x3_kerl_ready_i)       lat_q <= 3'd1;
    else if (state == WAIT_DATA)                                  lat_q <= lat_q + 3'd1;
  end

  // Capture kernel words and loop-position tags together so they stay coherent while held
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kif.ker_data_o       <= '0;
      kif.ker_group_o      <= '0;
      kif.ker_last_depth_o <= 1'b0;
      kif.ker_last_group_o <= 1'b0;
    end else if (capture) begin
      kif.ker_data_o       <= {kif.exp_3x3_kerl_4_data_i, kif.exp_3x3_kerl_3_data_i,
                               kif.exp_3x3_kerl_2_data_i, kif.exp_3x3_kerl_1_data_i};
      kif.ker_group_o      <= g_q;
      kif.ker_last_depth_o <= last_d;
      kif.ker_last_group_o <= last_g;
    end
  end

`ifdef EXP3_FETCH_PERF_CNT_EN
  logic stall_cyc;
  assign stall_cyc = busy_o && (((state == WAIT_RDY) && !kif.exp_3x3_kerl_ready_i) ||
                                ((state == HOLD) && !kif.ker_accept_i));

  // Saturating stall counter, cleared when a layer starts and frozen once the layer is done
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                      stall_cnt_o <= '0;
    else if (state == IDLE && start_i)              stall_cnt_o <= '0;
    else if (stall_cyc && stall_cnt_o != 24'hFFFFFF) stall_cnt_o <= stall_cnt_o + 24'd1;
  end
`endif

endmodule

// File: tb/tb_exp_3x3_kerl_fetch.sv
// tb/tb_exp_3x3_kerl_fetch.sv - randomized self-checking bench for exp_3x3_kerl_fetch against a loop-order reference model
module tb_exp_3x3_kerl_fetch;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  lim;
  logic [5:0]  dep;
  logic [6:0]  dim;
  logic        busy, done;
`ifdef EXP3_FETCH_PERF_CNT_EN
  logic [23:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exp_3x3_kerl_fetch_if kif();

  exp_3x3_kerl_fetch #(.RD_LATENCY(LAT)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .start_i                   (start),
    .one_exp3_ker_addr_limit_i (lim),
    .exp3_ker_depth_i          (dep),
    .layer_dimension_i         (dim),
    .kif                       (kif),
    .busy_o                    (busy),
`ifdef EXP3_FETCH_PERF_CNT_EN
    .stall_cnt_o               (stall_cnt),
`endif
    .done_o                    (done)
  );

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] rnd72();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  task automatic check_idle_outputs();
    check("rst_req",        288'(kif.exp_3x3_kerl_req_o), 288'(0));
    check("rst_valid",      288'(kif.ker_valid_o),        288'(0));
    check("rst_busy",       288'(busy),                   288'(0));
    check("rst_done",       288'(done),                   288'(0));
    check("rst_data",       kif.ker_data_o,               288'(0));
    check("rst_group",      288'(kif.ker_group_o),        288'(0));
    check("rst_last_depth", 288'(kif.ker_last_depth_o),   288'(0));
    check("rst_last_group", 288'(kif.ker_last_group_o),   288'(0));
  endtask

  // One full layer: model is the nested r/c/g/d loop written out as an expected-tag queue
  task automatic run_layer(input logic [6:0] lim_v, input logic [5:0] dep_v, input logic [6:0] dim_v,
                           input int rdy_pct, input int acc_pct, input int rgap_req, input int agap_req);
    logic [8:0]   exp_q[$];
    logic [8:0]   prev_tags, cur_tags;
    logic [287:0] staged, prev_data;
    int total, budget, cyc, due, reqs, words, dones, last_req, final_acc, done_cyc;
    int rgap_at, agap_at, stall_ref;
    logic outstanding, prev_valid, prev_acc, rdy, acc;

    for (int r = 0; r <= int'(dim_v); r++)
      for (int c = 0; c <= int'(dim_v); c++)
        for (int g = 0; g < int'(lim_v); g++)
          for (int d = 0; d <= int'(dep_v); d++)
            exp_q.push_back({7'(g), d == int'(dep_v), g == int'(lim_v) - 1});
    total = exp_q.size();
    budget = total * 40 + 100;
    due = -1; reqs = 0; words = 0; dones = 0; last_req = -100; final_acc = -100; done_cyc = -1;
    rgap_at = -100; agap_at = -100; stall_ref = 0;
    outstanding = 1'b0; prev_valid = 1'b0; prev_acc = 1'b0;
    staged = '0; prev_data = '0; prev_tags = '0;

    for (cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0);
      lim = lim_v; dep = dep_v; dim = dim_v;
      rdy = (cyc >= rgap_at && cyc < rgap_at + 10) ? 1'b0 : (int'($urandom_range(99)) < rdy_pct);
      acc = (cyc >= agap_at && cyc < agap_at + 5)  ? 1'b0 : (int'($urandom_range(99)) < acc_pct);
      kif.exp_3x3_kerl_ready_i = rdy;
      kif.ker_accept_i         = acc;
      if (cyc == due)
        {kif.exp_3x3_kerl_4_data_i, kif.exp_3x3_kerl_3_data_i,
         kif.exp_3x3_kerl_2_data_i, kif.exp_3x3_kerl_1_data_i} = staged;
      else
        {kif.exp_3x3_kerl_4_data_i, kif.exp_3x3_kerl_3_data_i,
         kif.exp_3x3_kerl_2_data_i, kif.exp_3x3_kerl_1_data_i} = {rnd72(), rnd72(), rnd72(), rnd72()};

      @(negedge clk);
      if (busy && ((!kif.ker_valid_o && !outstanding && !rdy) || (kif.ker_valid_o && !acc)))
        stall_ref++;
      if (cyc == 1) check("busy_after_start", 288'(busy), 288'(1));

      if (kif.exp_3x3_kerl_req_o) begin
        check("req_needs_ready", 288'(rdy), 288'(1));
        check("req_while_valid", 288'(kif.ker_valid_o), 288'(0));
        check("req_outstanding", 288'(outstanding), 288'(0));
        if (reqs > 0) check("req_spacing", 288'(cyc - last_req >= LAT + 2), 288'(1));
        for (int i = 0; i < 4; i++) staged = {staged[215:0], rnd72()};
        due = cyc + LAT;
        last_req = cyc;
        outstanding = 1'b1;
        if (reqs == rgap_req) rgap_at = cyc + LAT + 2;
        if (reqs == agap_req) agap_at = cyc + LAT + 1;
        reqs++;
      end

      if (prev_valid && prev_acc) check("valid_drops", 288'(kif.ker_valid_o), 288'(0));
      if (kif.ker_valid_o) begin
        cur_tags = {kif.ker_group_o, kif.ker_last_depth_o, kif.ker_last_group_o};
        if (!prev_valid || prev_acc) begin
          check("valid_latency", 288'(cyc - last_req), 288'(LAT + 1));
          check("valid_has_req", 288'(outstanding), 288'(1));
          outstanding = 1'b0;
          check("ker_data", kif.ker_data_o, staged);
          if (exp_q.size() == 0) check("extra_word", 288'(1), 288'(0));
          else                   check("ker_tags", 288'(cur_tags), 288'(exp_q[0]));
        end else begin
          check("data_stable", kif.ker_data_o, prev_data);
          check("tags_stable", 288'(cur_tags), 288'(prev_tags));
        end
        if (acc) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          words++;
          if (words == total) final_acc = cyc;
        end
        prev_data = kif.ker_data_o;
        prev_tags = cur_tags;
      end

      if (done) begin
        dones++;
        check("done_after_final", 288'(cyc), 288'(final_acc + 1));
        check("busy_low_at_done", 288'(busy), 288'(0));
        done_cyc = cyc;
      end
      prev_valid = kif.ker_valid_o;
      prev_acc   = acc;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;

    if (done_cyc < 0) check("done_timeout", 288'(0), 288'(1));
    check("req_count",  288'(reqs),  288'(total));
    check("word_count", 288'(words), 288'(total));
    check("done_count", 288'(dones), 288'(1));
`ifdef EXP3_FETCH_PERF_CNT_EN
    check("stall_cnt", 288'(stall_cnt), 288'(stall_ref));
    if (rgap_req >= 0) check("stall_ge_gap", 288'(stall_cnt >= 24'd10), 288'(1));
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; lim = 7'd1; dep = '0; dim = '0;
    kif.exp_3x3_kerl_ready_i = 1'b0;
    kif.ker_accept_i         = 1'b0;
    kif.exp_3x3_kerl_1_data_i = '0;
    kif.exp_3x3_kerl_2_data_i = '0;
    kif.exp_3x3_kerl_3_data_i = '0;
    kif.exp_3x3_kerl_4_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs();
    rst = 1'b0;

    run_layer(7'd1, 6'd0, 7'd0, 100, 100, -1, -1);
    run_layer(7'd2, 6'd2, 7'd1, 100, 100, -1, -1);
    run_layer(7'd3, 6'd1, 7'd1, 100, 100, 5, -1);
    run_layer(7'd2, 6'd1, 7'd1, 100, 100, -1, 3);
    for (int k = 0; k < 3; k++)
      run_layer(7'($urandom_range(4, 1)), 6'($urandom_range(3)), 7'($urandom_range(2)), 70, 60, -1, -1);

    // Reset while a RAM read is in flight, then confirm nothing leaks out
    @(posedge clk); #1;
    lim = 7'd2; dep = 6'd1; dim = 7'd0; start = 1'b1;
    kif.exp_3x3_kerl_ready_i = 1'b1; kif.ker_accept_i = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (kif.exp_3x3_kerl_req_o) seen = 1'b1;
      end
      check("rst_test_req_seen", 288'(seen), 288'(1));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 2 * LAT + 6; n++) begin
      @(negedge clk);
      check("post_rst_req",   288'(kif.exp_3x3_kerl_req_o), 288'(0));
      check("post_rst_valid", 288'(kif.ker_valid_o),        288'(0));
      check("post_rst_done",  288'(done),                   288'(0));
    end
    run_layer(7'd2, 6'd1, 7'd1, 80, 80, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exp_3x3_kerl_fetch.md
Name: exp_3x3_kerl_fetch

Overview:
- Requester-side controller for the expand 3x3 kernel RAM read port.
- Walks the pixel / kernel-group / depth loop for one layer and issues single-cycle `exp_3x3_kerl_req_o` pulses to the kernel read controller.
- Captures the four 72-bit kernel words after a fixed RAM latency and hands them to the expand 3x3 MAC array over a valid/accept handshake, with loop-position tags.

Parameters:
- RD_LATENCY, 2, cycles from the req pulse to valid kernel RAM q data (range 1..4).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle layer start; config sampled here
- one_exp3_ker_addr_limit_i  in  7  number of expand kernels / 4 (groups per pixel); 0 is illegal
- exp3_ker_depth_i  in  6  depth - 1
- layer_dimension_i  in  7  dimension - 1
- exp_3x3_kerl_ready_i  in  1  read controller has a layer loaded and can accept a req
- exp_3x3_kerl_req_o  out  1  one-cycle read request
- exp_3x3_kerl_1_data_i .. exp_3x3_kerl_4_data_i  in  72 each  kernel RAM q outputs
- ker_data_o  out  288  captured kernels {k4,k3,k2,k1}
- ker_valid_o  out  1  ker_data_o and tags valid
- ker_accept_i  in  1  MAC array consumes the word when valid & accept
- ker_group_o  out  7  kernel group index of the current word
- ker_last_depth_o  out  1  word is the final depth slice (depth counter == exp3_ker_depth)
- ker_last_group_o  out  1  word is the final group for this pixel
- busy_o  out  1  layer in progress
- done_o  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset values:
  - Outputs: req, valid, busy, done and both last flags = 0; ker_data_o = 0; ker_group_o = 0.
  - Counters are 0 and the FSM is in IDLE.
- Config latch: on start_i in IDLE, latch limit, depth and dimension into internal registers.
  - Clear the counters: depth d, group g, column c, row r.
  - Go to WAIT_RDY and set busy_o = 1.
  - start_i outside IDLE is ignored.
- Loop order:
  - d is innermost (0..depth_q).
  - Then g (0..limit_q-1).
  - Then c (0..dim_q).
  - Then r (0..dim_q).
  - Total words = (dim_q+1)^2 × limit_q × (depth_q+1).
- FSM:
  - IDLE -> WAIT_RDY on start_i.
  - WAIT_RDY: when exp_3x3_kerl_ready_i = 1, assert req_o for exactly one cycle (cycle T) and go to WAIT_DATA.
  - WAIT_DATA: a latency counter runs; on cycle T+RD_LATENCY, capture all four data inputs plus the current tags.
    - ker_valid_o = 1 from cycle T+RD_LATENCY+1.
    - Go to HOLD.
    - exp_3x3_kerl_ready_i falling during WAIT_DATA does not cancel the capture.
  - HOLD:
    - ker_data_o and tags are stable while valid & !accept.
    - On valid & accept: drop valid next cycle and advance the counters.
    - If the word just accepted was the final word, go to DONE; else go to WAIT_RDY.
  - DONE: done_o = 1 for one cycle, busy_o = 0, then IDLE.
- Flow limits:
  - Single outstanding request.
  - Minimum spacing between req pulses = RD_LATENCY + 2 cycles when accept is held high.
  - req_o is never asserted while ready_i = 0 or while valid_o = 1.
- Counter wrap: d wraps to 0 and increments g; g wraps at limit_q-1 and increments c; c wraps at dim_q and increments r.
- Final word: r == dim_q & c == dim_q & g == limit_q-1 & d == depth_q.
- Degenerate config: depth_q = 0 and dim_q = 0 are legal; with limit_q = 1, each word has both last flags set.
- Reset mid-operation: all state clears asynchronously. No req, valid or done is produced until the next start_i; any pending RAM data is discarded.

Optional Feature:
- Macro: EXP3_FETCH_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [23:0].
  - It counts cycles with busy_o = 1 and (state WAIT_RDY with ready_i = 0, or HOLD with accept_i = 0).
  - It clears on start_i, saturates at 24'hFFFFFF and holds its value after done_o.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Config limit=1, depth=0, dim=0; ready and accept held 1; start -> exactly 1 req.
  - valid_o rises RD_LATENCY+1 cycles after req; last_depth = last_group = 1; done_o 1 cycle after accept.
- Config limit=2, depth=2, dim=1; accept held 1 -> 24 req pulses.
  - Group/last tags follow the sequence g0d0, g0d1, g0d2(last_depth), g1d0 … repeated for 4 pixels; done_o once.
- Drive ready_i = 0 for 10 cycles mid-layer -> no req during the gap; the sequence resumes with the correct d/g; total word count is unchanged.
- Hold accept_i = 0 for 5 cycles with valid_o = 1 -> ker_data_o/tags stable, no new req; accept releases the next fetch.
- Assert rst_i during WAIT_DATA -> outputs return to reset values immediately; no valid_o; the following start runs a full layer cleanly.
- EXP3_FETCH_PERF_CNT_EN defined, same stimulus as the ready-gap test -> stall_cnt_o ≥ 10 and equal to the bench-counted stall cycles.
